// File: rtl/ptp_pkg.sv
// Shared definitions for the PTP servo: default widths, servo state encoding
// and the signed offset type used across the servo slice.
package ptp_pkg;

    localparam int DEF_TS_WIDTH = 31;
    localparam int DEF_NS_WIDTH = 27;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_STEP    = 3'd2,
        ST_SLEW    = 3'd3,
        ST_HOLD    = 3'd4
    } servo_state_t;

    typedef logic signed [DEF_TS_WIDTH-1:0] offset_t;

endpackage

// File: rtl/ptp_offset_calc.sv
// Combinational offset arithmetic: wrapped master-minus-local difference,
// its magnitude, and the slew command clamped to +/-SLEW_LIMIT.
module ptp_offset_calc
    import ptp_pkg::*;
#(
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int NS_WIDTH   = DEF_NS_WIDTH,
    parameter int SLEW_LIMIT = 16
) (
    input  logic [TS_WIDTH-1:0]        master_ts,
    input  logic [TS_WIDTH-1:0]        local_ts,
    output logic signed [TS_WIDTH-1:0] offset,
    output logic [TS_WIDTH-1:0]        abs_offset,
    output logic [NS_WIDTH-1:0]        slew_ns
);

    localparam logic [TS_WIDTH-1:0] LIMIT_TS     = TS_WIDTH'(SLEW_LIMIT);
    localparam logic [NS_WIDTH-1:0] POS_LIMIT_NS = NS_WIDTH'(SLEW_LIMIT);
    localparam logic [NS_WIDTH-1:0] NEG_LIMIT_NS = NS_WIDTH'(-SLEW_LIMIT);

    logic [TS_WIDTH-1:0] diff_s;

    // Modulo-2^TS_WIDTH difference; the most negative value's magnitude still fits unsigned.
    always_comb begin
        diff_s = master_ts - local_ts;
        offset = $signed(diff_s);
        if (diff_s[TS_WIDTH-1]) begin
            abs_offset = (~diff_s) + TS_WIDTH'(1);
        end else begin
            abs_offset = diff_s;
        end
        if (abs_offset > LIMIT_TS) begin
            slew_ns = diff_s[TS_WIDTH-1] ? NEG_LIMIT_NS : POS_LIMIT_NS;
        end else begin
            slew_ns = diff_s[NS_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ptp_servo.sv
// PTP clock servo: samples master/local time, then either steps the local
// clock or slews it while integrating drift, and reports lock status.
module ptp_servo
    import ptp_pkg::*;
#(
    parameter int TS_WIDTH       = DEF_TS_WIDTH,
    parameter int NS_WIDTH       = DEF_NS_WIDTH,
    parameter int NOM_PERIOD     = 4,
    parameter int STEP_THRESH    = 1000,
    parameter int SLEW_LIMIT     = 16,
    parameter int HOLDOFF        = 8,
    parameter int DRIFT_SHIFT    = 2,
    parameter int DRIFT_INTERVAL = 64,
    parameter int LOCK_COUNT     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TS_WIDTH-1:0] input_ts,
    input  logic                input_ts_valid,
    output logic                input_ts_ready,
    input  logic [TS_WIDTH-1:0] local_ts,
    output logic [NS_WIDTH-1:0] output_period_ns,
    output logic                output_period_valid,
    output logic [NS_WIDTH-1:0] output_adj_ns,
    output logic [NS_WIDTH-1:0] output_adj_count,
    output logic                output_adj_valid,
    output logic [NS_WIDTH-1:0] output_drift_ns,
    output logic [NS_WIDTH-1:0] output_drift_count,
    output logic                output_drift_valid,
    output logic [TS_WIDTH-1:0] offset_out,
    output logic                locked
);

    localparam int SUM_W = ((TS_WIDTH > NS_WIDTH) ? TS_WIDTH : NS_WIDTH) + 2;
    localparam int LC_W  = $clog2(LOCK_COUNT + 1);
    localparam int HC_W  = $clog2(HOLDOFF + 1);

    localparam logic [TS_WIDTH-1:0]     STEP_THRESH_TS = TS_WIDTH'(STEP_THRESH);
    localparam logic [TS_WIDTH-1:0]     SLEW_LIMIT_TS  = TS_WIDTH'(SLEW_LIMIT);
    localparam logic [NS_WIDTH-1:0]     DRIFT_CNT_NS   = NS_WIDTH'(DRIFT_INTERVAL);
    localparam logic [LC_W-1:0]         LOCK_LC        = LC_W'(LOCK_COUNT);
    localparam logic [HC_W-1:0]         HOLD_LAST      = HC_W'(HOLDOFF - 1);
    localparam logic signed [SUM_W-1:0] DRIFT_MAX      = SUM_W'((longint'(1) << (NS_WIDTH - 1)) - longint'(1));
    localparam logic signed [SUM_W-1:0] DRIFT_MIN      = -DRIFT_MAX;

    // Symmetric saturation of the widened drift sum back into the command width.
    function automatic logic signed [NS_WIDTH-1:0] sat_drift(input logic signed [SUM_W-1:0] v);
        if (v > DRIFT_MAX) begin
            sat_drift = NS_WIDTH'(DRIFT_MAX);
        end else if (v < DRIFT_MIN) begin
            sat_drift = NS_WIDTH'(DRIFT_MIN);
        end else begin
            sat_drift = v[NS_WIDTH-1:0];
        end
    endfunction

    servo_state_t               state_r, state_nxt_s;
    logic [TS_WIDTH-1:0]        master_ts_r, master_ts_nxt_s;
    logic [TS_WIDTH-1:0]        local_ts_r, local_ts_nxt_s;
    logic [HC_W-1:0]            hold_cnt_r, hold_cnt_nxt_s;
    logic [LC_W-1:0]            lock_cnt_r, lock_cnt_nxt_s, lock_inc_s;
    logic signed [NS_WIDTH-1:0] drift_acc_r, drift_acc_nxt_s, drift_sat_s;
    logic signed [SUM_W-1:0]    drift_sum_s;
    logic                       ready_r, started_r, period_valid_r;
    logic [NS_WIDTH-1:0]        adj_ns_r, adj_ns_nxt_s, adj_count_r, adj_count_nxt_s;
    logic                       adj_valid_r, adj_valid_nxt_s;
    logic [NS_WIDTH-1:0]        drift_ns_r, drift_ns_nxt_s, drift_count_r, drift_count_nxt_s;
    logic                       drift_valid_r, drift_valid_nxt_s;
    logic [TS_WIDTH-1:0]        offset_r, offset_nxt_s;
    logic                       locked_r, locked_nxt_s;
    logic                       accept_s, is_step_s;
    logic signed [TS_WIDTH-1:0] offset_s;
    logic [TS_WIDTH-1:0]        abs_offset_s;
    logic [NS_WIDTH-1:0]        slew_ns_s;

    ptp_offset_calc #(
        .TS_WIDTH   (TS_WIDTH),
        .NS_WIDTH   (NS_WIDTH),
        .SLEW_LIMIT (SLEW_LIMIT)
    ) u_offset_calc (
        .master_ts  (master_ts_r),
        .local_ts   (local_ts_r),
        .offset     (offset_s),
        .abs_offset (abs_offset_s),
        .slew_ns    (slew_ns_s)
    );

    assign accept_s    = (state_r == ST_IDLE) && ready_r && input_ts_valid;
    assign is_step_s   = abs_offset_s > STEP_THRESH_TS;
    assign lock_inc_s  = (lock_cnt_r == LOCK_LC) ? lock_cnt_r : lock_cnt_r + LC_W'(1);
    assign drift_sum_s = SUM_W'(drift_acc_r) + SUM_W'(offset_s >>> DRIFT_SHIFT);
    assign drift_sat_s = sat_drift(drift_sum_s);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; samples offered while busy simply wait for ready.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = accept_s ? ST_COMPUTE : ST_IDLE;
            ST_COMPUTE: state_nxt_s = is_step_s ? ST_STEP : ST_SLEW;
            ST_STEP:    state_nxt_s = ST_HOLD;
            ST_SLEW:    state_nxt_s = ST_HOLD;
            ST_HOLD:    state_nxt_s = (hold_cnt_r == HOLD_LAST) ? ST_IDLE : ST_HOLD;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath; commands are formed in COMPUTE
    // so they become visible during the STEP/SLEW cycle.
    always_comb begin
        master_ts_nxt_s   = master_ts_r;
        local_ts_nxt_s    = local_ts_r;
        hold_cnt_nxt_s    = HC_W'(0);
        lock_cnt_nxt_s    = lock_cnt_r;
        locked_nxt_s      = locked_r;
        drift_acc_nxt_s   = drift_acc_r;
        offset_nxt_s      = offset_r;
        adj_ns_nxt_s      = adj_ns_r;
        adj_count_nxt_s   = adj_count_r;
        adj_valid_nxt_s   = 1'b0;
        drift_ns_nxt_s    = drift_ns_r;
        drift_count_nxt_s = drift_count_r;
        drift_valid_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    master_ts_nxt_s = input_ts;
                    local_ts_nxt_s  = local_ts;
                end else begin
                    master_ts_nxt_s = master_ts_r;
                end
            end
            ST_COMPUTE: begin
                offset_nxt_s    = $unsigned(offset_s);
                adj_count_nxt_s = NS_WIDTH'(0);
                adj_valid_nxt_s = 1'b1;
                if (is_step_s) begin
                    adj_ns_nxt_s   = offset_s[NS_WIDTH-1:0];
                    lock_cnt_nxt_s = LC_W'(0);
                    locked_nxt_s   = 1'b0;
                end else begin
                    adj_ns_nxt_s      = slew_ns_s;
                    drift_acc_nxt_s   = drift_sat_s;
                    drift_ns_nxt_s    = drift_sat_s;
                    drift_count_nxt_s = DRIFT_CNT_NS;
                    drift_valid_nxt_s = 1'b1;
                    if (abs_offset_s <= SLEW_LIMIT_TS) begin
                        lock_cnt_nxt_s = lock_inc_s;
                        locked_nxt_s   = (lock_inc_s == LOCK_LC);
                    end else begin
                        lock_cnt_nxt_s = LC_W'(0);
                        locked_nxt_s   = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_nxt_s = hold_cnt_r + HC_W'(1);
                end else begin
                    hold_cnt_nxt_s = HC_W'(0);
                end
            end
            default: hold_cnt_nxt_s = HC_W'(0);
        endcase
    end

    // Datapath and output registers; reset abandons any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master_ts_r    <= '0;
            local_ts_r     <= '0;
            hold_cnt_r     <= '0;
            lock_cnt_r     <= '0;
            locked_r       <= 1'b0;
            drift_acc_r    <= '0;
            offset_r       <= '0;
            adj_ns_r       <= '0;
            adj_count_r    <= '0;
            adj_valid_r    <= 1'b0;
            drift_ns_r     <= '0;
            drift_count_r  <= '0;
            drift_valid_r  <= 1'b0;
            ready_r        <= 1'b0;
            started_r      <= 1'b0;
            period_valid_r <= 1'b0;
        end else begin
            master_ts_r    <= master_ts_nxt_s;
            local_ts_r     <= local_ts_nxt_s;
            hold_cnt_r     <= hold_cnt_nxt_s;
            lock_cnt_r     <= lock_cnt_nxt_s;
            locked_r       <= locked_nxt_s;
            drift_acc_r    <= drift_acc_nxt_s;
            offset_r       <= offset_nxt_s;
            adj_ns_r       <= adj_ns_nxt_s;
            adj_count_r    <= adj_count_nxt_s;
            adj_valid_r    <= adj_valid_nxt_s;
            drift_ns_r     <= drift_ns_nxt_s;
            drift_count_r  <= drift_count_nxt_s;
            drift_valid_r  <= drift_valid_nxt_s;
            ready_r        <= (state_nxt_s == ST_IDLE);
            started_r      <= 1'b1;
            period_valid_r <= ~started_r;
        end
    end

    assign input_ts_ready      = ready_r;
    assign output_period_ns    = NS_WIDTH'(NOM_PERIOD);
    assign output_period_valid = period_valid_r;
    assign output_adj_ns       = adj_ns_r;
    assign output_adj_count    = adj_count_r;
    assign output_adj_valid    = adj_valid_r;
    assign output_drift_ns     = drift_ns_r;
    assign output_drift_count  = drift_count_r;
    assign output_drift_valid  = drift_valid_r;
    assign offset_out          = offset_r;
    assign locked              = locked_r;

endmodule

// File: tb/tb_ptp_servo.sv
// Self-checking bench for ptp_servo: directed literal cases plus randomized
// samples compared every cycle against an arithmetic model of the servo.
module tb_ptp_servo;

    localparam int     TSW     = 31;
    localparam int     NSW     = 27;
    localparam longint TS_MASK = (longint'(1) << TSW) - 1;
    localparam longint NS_MASK = (longint'(1) << NSW) - 1;
    localparam longint DMAX    = (longint'(1) << (NSW - 1)) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [TSW-1:0] input_ts;
    logic           input_ts_valid;
    logic           input_ts_ready;
    logic [TSW-1:0] local_ts;
    logic [NSW-1:0] output_period_ns, output_adj_ns, output_adj_count;
    logic [NSW-1:0] output_drift_ns, output_drift_count;
    logic           output_period_valid, output_adj_valid, output_drift_valid;
    logic [TSW-1:0] offset_out;
    logic           locked;

    ptp_servo dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .input_ts            (input_ts),
        .input_ts_valid      (input_ts_valid),
        .input_ts_ready      (input_ts_ready),
        .local_ts            (local_ts),
        .output_period_ns    (output_period_ns),
        .output_period_valid (output_period_valid),
        .output_adj_ns       (output_adj_ns),
        .output_adj_count    (output_adj_count),
        .output_adj_valid    (output_adj_valid),
        .output_drift_ns     (output_drift_ns),
        .output_drift_count  (output_drift_count),
        .output_drift_valid  (output_drift_valid),
        .offset_out          (offset_out),
        .locked              (locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: k = rising edges since reset release.
    int     k = 0;
    int     ready_from = 1;
    int     pend_edge = -1;
    int     acc_count = 0;
    int     lcnt = 0;
    longint drift = 0;
    longint pend_adj = 0, pend_drift = 0, pend_off = 0;
    bit     pend_slew = 0, pend_locked = 0;
    longint exp_offset = 0;
    bit     exp_locked = 0;

    task automatic model_accept();
        longint d, ad, adjv;
        d = (longint'(input_ts) - longint'(local_ts)) & TS_MASK;
        if (d > (TS_MASK >> 1)) d = d - (TS_MASK + 1);
        ad = (d < 0) ? -d : d;
        acc_count++;
        pend_edge  = k + 1;
        ready_from = k + 10;
        pend_off   = d & TS_MASK;
        if (ad > 1000) begin
            pend_adj    = d & NS_MASK;
            pend_slew   = 1'b0;
            lcnt        = 0;
            pend_locked = 1'b0;
        end else begin
            adjv     = (d > 16) ? 64'sd16 : ((d < -16) ? -64'sd16 : d);
            pend_adj = adjv & NS_MASK;
            drift    = drift + (d >>> 2);
            if (drift > DMAX) drift = DMAX;
            else if (drift < -DMAX) drift = -DMAX;
            pend_drift = drift & NS_MASK;
            pend_slew  = 1'b1;
            if (ad <= 16) lcnt = (lcnt < 4) ? lcnt + 1 : 4;
            else lcnt = 0;
            pend_locked = (lcnt == 4);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; ready_from = 1; pend_edge = -1; lcnt = 0; drift = 0;
                exp_offset = 0; exp_locked = 1'b0;
            end else begin
                k++;
                if (k == pend_edge) begin
                    exp_offset = pend_off;
                    exp_locked = pend_locked;
                end
                if (input_ts_valid && (k - 1 >= ready_from)) model_accept();
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("ready", input_ts_ready, (k >= ready_from) ? 1 : 0);
                chk("period_valid", output_period_valid, (k == 1) ? 1 : 0);
                chk("period_ns", output_period_ns, 4);
                chk("adj_valid", output_adj_valid, (k == pend_edge) ? 1 : 0);
                chk("drift_valid", output_drift_valid, (k == pend_edge && pend_slew) ? 1 : 0);
                chk("offset_out", offset_out, exp_offset);
                chk("locked", locked, exp_locked);
                if (k == pend_edge) begin
                    chk("adj_ns", output_adj_ns, pend_adj);
                    chk("adj_count", output_adj_count, 0);
                    if (pend_slew) begin
                        chk("drift_ns", output_drift_ns, pend_drift);
                        chk("drift_count", output_drift_count, 64);
                    end
                end
            end
        end
    end

    task automatic send(input logic [TSW-1:0] mts, input logic [TSW-1:0] lts);
        int n0;
        bit got;
        @(negedge clk);
        input_ts = mts; local_ts = lts; input_ts_valid = 1'b1;
        n0 = acc_count; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (acc_count != n0) got = 1'b1;
        end
        input_ts_valid = 1'b0;
        chk("accept_in_time", got, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, input_ts_ready, 0);
        chk({tag, "_period_valid"}, output_period_valid, 0);
        chk({tag, "_adj_valid"}, output_adj_valid, 0);
        chk({tag, "_adj_ns"}, output_adj_ns, 0);
        chk({tag, "_adj_count"}, output_adj_count, 0);
        chk({tag, "_drift_valid"}, output_drift_valid, 0);
        chk({tag, "_drift_ns"}, output_drift_ns, 0);
        chk({tag, "_drift_count"}, output_drift_count, 0);
        chk({tag, "_offset_out"}, offset_out, 0);
        chk({tag, "_locked"}, locked, 0);
    endtask

    longint edge_offs[9] = '{16, -16, 17, -17, 1000, -1000, 1001, -1001, 0};

    initial begin
        longint off;
        rst_n = 1'b0; input_ts_valid = 1'b0; input_ts = '0; local_ts = '0;
        #3;
        chk_all_zero("reset");
        #19 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("first_period_pulse", output_period_valid, 1);
        chk("first_ready", input_ts_ready, 1);
        @(posedge clk); #2;
        chk("period_pulse_end", output_period_valid, 0);

        // Large offset: step command, no drift, ready back after the hold window.
        send(31'd5000, 31'd1000);
        @(posedge clk); #2;
        chk("step_adj_valid", output_adj_valid, 1);
        chk("step_adj_ns", output_adj_ns, 4000);
        chk("step_adj_count", output_adj_count, 0);
        chk("step_no_drift", output_drift_valid, 0);
        chk("step_offset", offset_out, 4000);
        @(posedge clk); #2;
        chk("step_pulse_end", output_adj_valid, 0);
        repeat (7) @(posedge clk);
        #2 chk("hold_last_not_ready", input_ts_ready, 0);
        @(posedge clk); #2;
        chk("hold_done_ready", input_ts_ready, 1);

        // Negative slew clamp and drift from zero.
        send(31'd1000, 31'd1040);
        @(posedge clk); #2;
        chk("neg_adj_ns", output_adj_ns, 64'h7FFFFF0);
        chk("neg_drift_ns", output_drift_ns, 64'h7FFFFF6);
        chk("neg_drift_valid", output_drift_valid, 1);
        chk("neg_offset", offset_out, 64'h7FFFFFD8);

        // Reset while in HOLD.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("hold_reset");
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rerelease_period_pulse", output_period_valid, 1);
        chk("rerelease_ready", input_ts_ready, 1);

        // Small positive slew: adj and drift pulse together.
        send(31'd1010, 31'd1000);
        @(posedge clk); #2;
        chk("slew_adj_ns", output_adj_ns, 10);
        chk("slew_drift_ns", output_drift_ns, 2);
        chk("slew_drift_count", output_drift_count, 64);
        chk("slew_both_valid", {output_adj_valid, output_drift_valid}, 3);

        // Wrapped offset.
        send(31'd5, 31'h7FFFFFFD);
        @(posedge clk); #2;
        chk("wrap_adj_ns", output_adj_ns, 8);
        chk("wrap_offset", offset_out, 8);

        // Lock acquisition and loss.
        send(31'd3000, 31'd1000);
        @(posedge clk); #2;
        chk("prelock_step_locked", locked, 0);
        for (int i = 0; i < 4; i++) begin
            send(31'd1003, 31'd1000);
            @(posedge clk); #2;
            chk("lock_progress", locked, (i == 3) ? 1 : 0);
        end
        send(31'd3000, 31'd1000);
        @(posedge clk); #2;
        chk("unlock_step_locked", locked, 0);
        chk("unlock_step_adj_valid", output_adj_valid, 1);

        // Randomized traffic, including offers while busy and one asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            input_ts_valid = ($urandom_range(0, 2) != 0);
            local_ts = 31'($urandom);
            case ($urandom_range(0, 4))
                0: off = longint'($urandom_range(0, 32)) - 16;
                1: off = longint'($urandom_range(17, 1000));
                2: off = longint'($urandom_range(1001, 2000000));
                3: off = longint'($urandom);
                default: off = edge_offs[$urandom_range(0, 8)];
            endcase
            if ($urandom_range(0, 1) != 0) off = -off;
            input_ts = 31'(longint'(local_ts) + off);
            if (i == 700) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        input_ts_valid = 1'b0;
        repeat (15) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptp_servo.md
PTP_SERVO -- requirements
Module: ptp_servo

Interface
REQ-001 Parameters SHALL be: TS_WIDTH, 31, timestamp width; NS_WIDTH, 27, adjustment field width; NOM_PERIOD, 4, nominal ns per cycle; STEP_THRESH, 1000, step/slew boundary in ns; SLEW_LIMIT, 16, max slew per sample in ns; HOLDOFF, 8, settle cycles after each correction; DRIFT_SHIFT, 2, drift gain shift; DRIFT_INTERVAL, 64, drift application period in cycles; LOCK_COUNT, 4, good samples required for lock.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 input_ts  in  TS_WIDTH  master timestamp sample.
REQ-005 input_ts_valid  in  1  sample valid.
REQ-006 input_ts_ready  out  1  sample accepted when valid && ready.
REQ-007 local_ts  in  TS_WIDTH  local PTP clock time output.
REQ-008 output_period_ns / output_period_valid  out  NS_WIDTH / 1  period command to local clock.
REQ-009 output_adj_ns / output_adj_count / output_adj_valid  out  NS_WIDTH / NS_WIDTH / 1  offset command.
REQ-010 output_drift_ns / output_drift_count / output_drift_valid  out  NS_WIDTH / NS_WIDTH / 1  drift command.
REQ-011 offset_out  out  TS_WIDTH  last measured signed offset; locked  out  1  servo lock status.

Function
REQ-012 States SHALL be IDLE, COMPUTE, STEP, SLEW, HOLD; input_ts_ready SHALL be 1 only in IDLE.
REQ-013 On accept, input_ts and local_ts SHALL be captured on the same edge and the FSM SHALL enter COMPUTE.
REQ-014 COMPUTE SHALL form offset = input_ts - local_ts modulo 2^TS_WIDTH, interpreted as TS_WIDTH-bit signed, and register it to offset_out.
REQ-015 From COMPUTE: |offset| > STEP_THRESH -> STEP; otherwise -> SLEW (offset 0 included).
REQ-016 STEP SHALL drive output_adj_ns = offset[NS_WIDTH-1:0], output_adj_count = 0, output_adj_valid = 1 for exactly one cycle, clear locked and lock counter, then go to HOLD.
REQ-017 SLEW SHALL drive output_adj_ns = offset clamped to +/-SLEW_LIMIT (two's complement), output_adj_count = 0, output_adj_valid one-cycle pulse.
REQ-018 SLEW SHALL update drift_acc += offset >>> DRIFT_SHIFT (arithmetic), saturating at +/-(2^(NS_WIDTH-1)-1), and in the same cycle drive output_drift_ns = drift_acc (new value), output_drift_count = DRIFT_INTERVAL, output_drift_valid one-cycle pulse.
REQ-019 In SLEW, |offset| <= SLEW_LIMIT SHALL increment the lock counter (saturating at LOCK_COUNT); otherwise counter and locked SHALL clear.
REQ-020 locked SHALL assert in the cycle the lock counter reaches LOCK_COUNT.
REQ-021 Command pulses SHALL appear in the second cycle after the accept edge (accept edge -> COMPUTE -> STEP/SLEW).
REQ-022 HOLD SHALL last exactly HOLDOFF cycles, then return to IDLE; input_ts_valid during COMPUTE/STEP/SLEW/HOLD SHALL be held off, not dropped or queued.
REQ-023 output_period_ns SHALL equal NOM_PERIOD constantly; output_period_valid SHALL pulse for one cycle on the first edge after rst_n deasserts.
REQ-024 All *_valid outputs SHALL be registered, single-cycle, and 0 outside the states named above.
REQ-025 STEP SHALL not modify drift_acc.

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, all *_valid 0, output_adj_ns/count 0, output_drift_ns/count 0, offset_out 0, locked 0, drift_acc 0, lock counter 0, hold counter 0.
REQ-027 input_ts_ready SHALL be 0 while rst_n is low and 1 from the first cycle after release.
REQ-028 Reset mid-operation (any state) SHALL abandon the sample with no partial command pulse.

Structure
REQ-029 Shared package ptp_pkg SHALL hold TS_WIDTH/NS_WIDTH defaults, the servo state enum typedef, and a signed offset typedef.
REQ-030 Subtraction, absolute value, and clamp SHALL live in a combinational sub-module ptp_offset_calc; the FSM, counters, and drift accumulator live in ptp_servo.

Verification
REQ-031 input_ts=5000, local_ts=1000 -> offset 4000, STEP: adj_ns=4000, adj_count=0, one-cycle pulse 2 cycles after accept, no drift pulse, ready again after 8 HOLD cycles.
REQ-032 input_ts=1010, local_ts=1000 -> adj_ns=10, drift_ns=2, drift_count=64, adj and drift pulses in the same cycle.
REQ-033 input_ts=1000, local_ts=1040 -> offset -40: adj_ns=-16 (27'h7FFFFF0), drift_ns=-10 from zero.
REQ-034 input_ts=5, local_ts=2^31-3 -> offset +8 (wrap): SLEW, adj_ns=8.
REQ-035 Four samples with offset 3 -> locked=1 on the fourth SLEW cycle; next offset 2000 -> locked=0 in the STEP cycle.
REQ-036 rst_n low during HOLD -> all outputs 0 asynchronously; after release, period pulse on first edge, ready=1, next sample processed normally.
